// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the IMEM program loader: byte/header sizing,
// default widths for PC, instruction word and IMEM size, the loader state
// encoding and a helper that converts an IMEM byte size into a word capacity.
package imem_loader_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int HDR_BYTES      = 4;
    localparam int DEF_PC_WIDTH   = 32;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_IMEM_DEPTH = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Number of 32-bit words that fit into an IMEM of the given byte size.
    function automatic logic [31:0] max_words(input int depth_bytes);
        return 32'(depth_bytes / 4);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Bundles the byte-stream handshake and the IMEM write port of the loader.
//   in_valid / in_data : byte source -> loader
//   in_ready           : loader -> byte source (transfer = in_valid & in_ready)
//   wr_en / wr_addr / wr_data : loader -> IMEM write port
// Modports:
//   master : the loader (drives in_ready and the IMEM write port)
//   slave  : the environment (byte source plus IMEM)
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH
);

    logic                  in_valid;
    logic [BYTE_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [PC_WIDTH-1:0]   wr_addr;
    logic [INST_WIDTH-1:0] wr_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/imem_loader_le_word_packer.sv
// le_word_packer
// Little-endian 4-byte lane register. Each accepted byte is written into the
// lane selected by an internal byte index (first byte -> [7:0]); the index
// wraps after the last lane so the next word starts at lane 0 again.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear of word and byte index
//   accept       : a byte is transferred this cycle
//   in_byte      : the byte being transferred
//   word         : registered lane contents
//   complete     : this accept fills the last lane (combinational)
module le_word_packer
    import imem_loader_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            accept,
    input  logic [BYTE_WIDTH-1:0]           in_byte,
    output logic [HDR_BYTES*BYTE_WIDTH-1:0] word,
    output logic                            complete
);

    localparam int               IDX_W    = $clog2(HDR_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BYTES - 1);

    logic [IDX_W-1:0] byte_idx;

    assign complete = accept && (byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (accept) begin
            word[byte_idx*BYTE_WIDTH +: BYTE_WIDTH] <= in_byte;
            byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Byte-stream program loader. Reads a 4-byte little-endian word count,
// then packs the following bytes little-endian into instruction words and
// writes them to IMEM at byte addresses 0, 4, 8, ... The CPU is held in
// reset while a load is running or after a rejected header.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle pulse, starts a load from IDLE/DONE/ERR
//   bus          : byte stream handshake and IMEM write port (master side)
//   busy         : load in progress
//   done         : load finished successfully, held until next start
//   err          : header count exceeded IMEM capacity, held until next start
//   cpu_hold     : keep CPU in reset (busy or err)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cpu_hold
);

    localparam logic [31:0] MAX_WORDS = max_words(IMEM_DEPTH);
    localparam int          WIDX_W    = PC_WIDTH - 2;

    state_t                            state;
    state_t                            state_nxt;
    logic [HDR_BYTES*BYTE_WIDTH-1:0]   packed_word;
    logic                              word_done;
    logic                              accept;
    logic                              clear;
    logic [31:0]                       count;
    logic [31:0]                       header_count;
    logic [WIDX_W-1:0]                 word_idx;
    logic                              last_word;

    assign accept = bus.in_valid && bus.in_ready;

    // The 4th header byte is still on in_data when the decision is made, so
    // the full count is assembled from it and the three lanes already held.
    assign header_count = {bus.in_data, packed_word[(HDR_BYTES-1)*BYTE_WIDTH-1:0]};
    assign last_word    = (32'(word_idx) + 32'd1) == count;

    le_word_packer u_packer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .accept   (accept),
        .in_byte  (bus.in_data),
        .word     (packed_word),
        .complete (word_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_nxt = ST_HDR;
                    clear     = 1'b1;
                end
            end
            ST_HDR: begin
                if (word_done) begin
                    if (header_count == 32'd0) begin
                        state_nxt = ST_DONE;
                    end else if (header_count > MAX_WORDS) begin
                        state_nxt = ST_ERR;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_nxt = last_word ? ST_DONE : ST_DATA;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if ((state == ST_HDR) && word_done) begin
            count <= header_count;
        end
    end

    // Word index advances as the write leaves WRITE, so wr_addr is stable
    // for the whole cycle wr_en is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx <= '0;
        end else if (clear) begin
            word_idx <= '0;
        end else if (state == ST_WRITE) begin
            word_idx <= word_idx + WIDX_W'(1);
        end
    end

    assign bus.in_ready = (state == ST_HDR) || (state == ST_DATA);
    assign bus.wr_en    = (state == ST_WRITE);
    assign bus.wr_addr  = {word_idx, 2'b00};
    assign bus.wr_data  = INST_WIDTH'(packed_word);
    assign busy         = (state == ST_HDR) || (state == ST_DATA) || (state == ST_WRITE);
    assign done         = (state == ST_DONE);
    assign err          = (state == ST_ERR);
    assign cpu_hold     = busy || err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader with PC_WIDTH=8, IMEM_DEPTH=64 (16 words).
// Inputs are driven and outputs sampled on the falling clock edge; IMEM
// writes are logged on the falling edge whenever wr_en is high.
module tb_imem_loader;

    localparam int PC_WIDTH   = 8;
    localparam int INST_WIDTH = 32;
    localparam int IMEM_DEPTH = 64;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic busy;
    logic done;
    logic err;
    logic cpu_hold;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    imem_loader_if #(.PC_WIDTH(PC_WIDTH), .INST_WIDTH(INST_WIDTH)) bus ();

    imem_loader #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_addr_log.push_back(32'(bus.wr_addr));
            wr_data_log.push_back(32'(bus.wr_data));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_output({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
        check_output({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
        check_output({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
        check_output({tag, "_busy"},     32'(busy),         32'd0);
        check_output({tag, "_done"},     32'(done),         32'd0);
        check_output({tag, "_err"},      32'(err),          32'd0);
        check_output({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte and returns on the falling edge after it was taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check_output("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);
        if (gaps && $urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[k*8 +: 8], gaps);
        end
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic apply_stimulus();
        logic [31:0] words_e[3];
        logic [31:0] exp_word;
        words_e[0] = 32'h0000_0013;
        words_e[1] = 32'hDEAD_BEEF;
        words_e[2] = 32'h8000_0001;

        // Reset state
        reset_n      = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        // Two-word load with back-to-back bytes
        $display("[TB] two-word load");
        clear_log();
        pulse_start();
        check_output("a_busy",     32'(busy),         32'd1);
        check_output("a_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("a_hold",     32'(cpu_hold),     32'd1);
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0513, 1'b0);
        check_output("a_w0_en",    32'(bus.wr_en),    32'd1);
        check_output("a_w0_rdy",   32'(bus.in_ready), 32'd0);
        check_output("a_w0_addr",  32'(bus.wr_addr),  32'h0);
        check_output("a_w0_data",  32'(bus.wr_data),  32'h0000_0513);
        send_word(32'h0010_0093, 1'b0);
        check_output("a_w1_addr",  32'(bus.wr_addr),  32'h4);
        check_output("a_w1_data",  32'(bus.wr_data),  32'h0010_0093);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_output("a_done",     32'(done),     32'd1);
        check_output("a_hold_off", 32'(cpu_hold), 32'd0);
        check_output("a_busy_off", 32'(busy),     32'd0);
        check_output("a_wr_en",    32'(bus.wr_en), 32'd0);
        check_output("a_nwr",      32'(wr_addr_log.size()), 32'd2);

        // Zero-count header
        $display("[TB] zero-count header");
        clear_log();
        pulse_start();
        check_output("b_done_clr", 32'(done), 32'd0);
        send_word(32'd0, 1'b0);
        bus.in_valid = 1'b0;
        check_output("b_done",  32'(done),     32'd1);
        check_output("b_hold",  32'(cpu_hold), 32'd0);
        @(negedge clk);
        check_output("b_nwr",   32'(wr_addr_log.size()), 32'd0);

        // Header one above capacity
        $display("[TB] over-capacity header");
        clear_log();
        pulse_start();
        send_word(32'd17, 1'b0);
        bus.in_valid = 1'b0;
        check_output("c_err",      32'(err),          32'd1);
        check_output("c_hold",     32'(cpu_hold),     32'd1);
        check_output("c_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("c_done",     32'(done),         32'd0);
        check_output("c_busy",     32'(busy),         32'd0);
        repeat (2) @(negedge clk);
        check_output("c_nwr",      32'(wr_addr_log.size()), 32'd0);
        pulse_start();
        check_output("c_err_clr",  32'(err),          32'd0);
        check_output("c_restart",  32'(bus.in_ready), 32'd1);

        // Full-capacity load with random gaps (already in HDR)
        $display("[TB] full-capacity load with gaps");
        clear_log();
        send_word(32'd16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            send_word({8'(i*4+4), 8'(i*4+3), 8'(i*4+2), 8'(i*4+1)}, 1'b1);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("d_done", 32'(done), 32'd1);
        check_output("d_nwr",  32'(wr_addr_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            exp_word = {8'(i*4+4), 8'(i*4+3), 8'(i*4+2), 8'(i*4+1)};
            if (i < wr_addr_log.size()) begin
                check_output($sformatf("d_addr%0d", i), wr_addr_log[i], 32'(i*4));
                check_output($sformatf("d_data%0d", i), wr_data_log[i], exp_word);
            end
        end

        // Reset in the middle of DATA
        $display("[TB] reset mid-load");
        pulse_start();
        send_word(32'd3, 1'b0);
        send_word(words_e[0], 1'b0);
        send_word(words_e[1], 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_values("e_rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_word(32'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_word(words_e[i], 1'b0);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_output("e_done", 32'(done), 32'd1);
        check_output("e_nwr",  32'(wr_addr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wr_addr_log.size()) begin
                check_output($sformatf("e_addr%0d", i), wr_addr_log[i], 32'(i*4));
                check_output($sformatf("e_data%0d", i), wr_data_log[i], words_e[i]);
            end
        end

        // start pulsed during DATA is ignored
        $display("[TB] start during DATA");
        clear_log();
        pulse_start();
        send_word(32'd1, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        bus.in_valid = 1'b0;
        pulse_start();
        check_output("f_busy",  32'(busy),         32'd1);
        check_output("f_ready", 32'(bus.in_ready), 32'd1);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        bus.in_valid = 1'b0;
        check_output("f_addr", 32'(bus.wr_addr), 32'h0);
        check_output("f_data", 32'(bus.wr_data), 32'hDEAD_BEEF);
        @(negedge clk);
        check_output("f_done", 32'(done), 32'd1);
        check_output("f_nwr",  32'(wr_addr_log.size()), 32'd1);
    endtask

    initial begin
        apply_stimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes instruction words into IMEM through its write port (`wr_en`/`wr_addr`/`wr_data`). It sits between a byte source (UART receiver or testbench driver) and IMEM. It parses a 4-byte word-count header, packs the following bytes little-endian into 32-bit instructions, and issues one IMEM write per word at consecutive byte addresses 0, 4, 8, …. It holds the CPU in reset (`cpu_hold`) while a load is in progress.

## Interface
- PC_WIDTH, `PC_WIDTH`, IMEM address width (byte address)
- INST_WIDTH, `INST_WIDTH`, instruction/word width (32)
- IMEM_DEPTH, `IMEM_DEPTH`, IMEM size in bytes; max words = IMEM_DEPTH/4

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready at rising edge
- wr_en  out  1  IMEM write strobe, one cycle per word
- wr_addr  out  PC_WIDTH  IMEM byte address of word (multiple of 4)
- wr_data  out  INST_WIDTH  packed word, first received byte in [7:0]
- busy  out  1  load in progress (HDR, DATA, WRITE)
- done  out  1  load completed successfully; held until next start
- err  out  1  header word count exceeds capacity; held until next start
- cpu_hold  out  1  keep CPU in reset; high while busy or err

## Operation
- States: IDLE, HDR, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start → HDR; clear byte index, word index, done, err. start in HDR/DATA/WRITE ignored.
- HDR: in_ready=1; collect 4 bytes little-endian into 32-bit `count`. After 4th byte: count==0 → DONE; count > IMEM_DEPTH/4 → ERR; else → DATA.
- DATA: in_ready=1; shift accepted bytes into the word at byte lane `byte_idx` (0..3). The 4th byte → WRITE.
- WRITE: in_ready=0; wr_en=1 for exactly one cycle; wr_addr = word_idx*4; wr_data = packed word. Then word_idx+1 == count → DONE, else → DATA with byte_idx=0.
- DONE: done=1, cpu_hold=0. ERR: err=1, cpu_hold=1. in_ready=0 in IDLE/DONE/ERR.
- wr_addr is computed at PC_WIDTH bits. The capacity check guarantees no wrap, so wr_addr never exceeds IMEM_DEPTH-4.
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- Reset mid-load: all state returns to reset values immediately. Words already written to IMEM are not restored.

## Timing
- Reset values: state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, err 0, cpu_hold 0, all counters 0.
- All outputs are registered or decoded from registered state; there is no combinational path from in_valid to in_ready.
- The 4th data byte of a word is accepted at edge N. wr_en is high in cycle N..N+1 and IMEM captures at edge N+1.
- Peak throughput: 4 bytes per 5 cycles.
- The last write's edge moves the state to DONE, so done is visible the following cycle.
- The 4th header byte's edge moves the state to DONE or ERR, or to DATA.
- start in the same cycle that DONE is entered is ignored; start is sampled only while already in DONE/ERR/IDLE.

## Structure
- Shared package/defines: state encoding localparams, HDR_BYTES=4, BYTE_WIDTH=8, and reuse of `PC_WIDTH`/`INST_WIDTH`/`IMEM_DEPTH`.
- Natural sub-module: `le_word_packer`, a 4-byte little-endian shift/lane register with byte_idx and a word-complete flag, used for both the header and the data.
- Top level holds the FSM, word counter, address generation and capacity check.

## Test plan
- Header 02 00 00 00, then bytes 13 05 00 00 93 00 10 00 → writes (0x0, 0x00000513) and (0x4, 0x00100093), then done=1 and cpu_hold=0.
- Header 00 00 00 00 → no wr_en, done=1 one cycle after the 4th byte.
- Header count = IMEM_DEPTH/4 + 1 → err=1, cpu_hold=1, no writes, in_ready=0; a subsequent start restarts in HDR with err cleared.
- in_valid toggled randomly with gaps, and in_valid held during WRITE → no byte lost or duplicated; wr_data matches the stream.
- Reset asserted mid-DATA (after 2 of 3 words) → all outputs at reset values; a fresh start with a full stream completes correctly.
- start pulsed during DATA → ignored; the load completes unchanged.
